// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared defaults and named constants for the multi-port register file.
// Holds the default geometry (width, index width, read port count), the
// stack-pointer preload defaults, the well-known register indices, and the
// enum that names where a read port takes its data from.
package reg_file_pkg;

    // Default geometry of the register file
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    // Stack pointer preload: register index and its value out of reset
    localparam int          DEF_SP_IDX  = 29;
    localparam logic [31:0] DEF_SP_INIT = 32'h0000_0FFF;

    // Well-known register indices
    localparam int ZERO_REG = 0;
    localparam int A1_REG   = 5;
    localparam int A3_REG   = 7;
    localparam int T3_REG   = 11;

    // Source selected by a read port, in falling priority order
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_WA    = 2'd1,
        SRC_WB    = 2'd2,
        SRC_STORE = 2'd3
    } rd_src_e;

endpackage

// File: rtl/reg_file_mp_bypass.sv
// rf_read_bypass
// One read port of the register file: forces register 0 to read zero,
// forwards same-cycle write data (port A before port B), and forwards the
// scoreboard busy bit, masking it when the register is being written now.
// Ports:
//   addr        read index
//   wa_*/wb_*   the two write ports, used for bypass and busy masking
//   stored_data value currently held in the addressed register
//   stored_busy busy bit currently held for the addressed register
//   data        combinational read data
//   busy        combinational busy flag
module rf_read_bypass
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              stored_busy,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    rd_src_e src;

    // Pick the data source. Register 0 beats everything, then a matching
    // port A write, then a matching port B write, then the stored value.
    // A write to register 0 never bypasses because the zero check wins.
    always_comb begin
        src = SRC_STORE;
        if (addr == '0) begin
            src = SRC_ZERO;
        end else if (wa_en && (wa_addr == addr)) begin
            src = SRC_WA;
        end else if (wb_en && (wb_addr == addr)) begin
            src = SRC_WB;
        end
    end

    // Steer the data and the busy flag from the chosen source. A register
    // being written this cycle reports not-busy because its producer is
    // completing right now; register 0 is never busy.
    always_comb begin
        data = stored_data;
        busy = stored_busy;
        case (src)
            SRC_ZERO: begin
                data = '0;
                busy = 1'b0;
            end
            SRC_WA: begin
                data = wa_data;
                busy = 1'b0;
            end
            SRC_WB: begin
                data = wb_data;
                busy = 1'b0;
            end
            default: begin
                data = stored_data;
                busy = stored_busy;
            end
        endcase
    end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp
// Multi-port register file with two prioritised write ports, NUM_RD
// combinational read ports with write-through bypass, and a per-register
// busy scoreboard. Register 0 is hardwired to zero; register SP_IDX is
// preloaded with SP_INIT on reset.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   rd_addr / rd_data          packed read indices / read data, port k in slice k
//   rd_busy                    per-read-port busy flag
//   wa_en/wa_addr/wa_data      write port A (wins over B on the same address)
//   wb_en/wb_addr/wb_data      write port B
//   sb_set_en/sb_set_addr      marks a register busy when a producer issues
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                NUM_RD  = DEF_NUM_RD,
    parameter int                SP_IDX  = DEF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(DEF_SP_INIT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    // Reject configurations the read mux and the preload cannot support
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("reg_file_mp: NUM_RD must be in 1..4");
    end
    if (SP_IDX == ZERO_REG || SP_IDX >= DEPTH) begin : g_bad_sp_idx
        $error("reg_file_mp: SP_IDX must be nonzero and inside the file");
    end

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic wa_live;
    logic wb_live;
    logic set_live;

    // Writes and scoreboard sets aimed at register 0 are dropped here so the
    // storage and scoreboard below never touch entry 0 outside reset.
    assign wa_live  = wa_en     && (wa_addr     != '0);
    assign wb_live  = wb_en     && (wb_addr     != '0);
    assign set_live = sb_set_en && (sb_set_addr != '0);

    // Register storage. Reset restores the preload and ignores any write.
    // Port B is applied first and port A second so that on an address
    // collision the later assignment, port A, is the one that commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            if (wb_live) begin
                regs[wb_addr] <= wb_data;
            end
            if (wa_live) begin
                regs[wa_addr] <= wa_data;
            end
        end
    end

    // Busy scoreboard. A completing write clears its register's bit and an
    // issuing producer sets it; the set is applied last so that a new
    // producer issued in the same cycle as the old one retires keeps the
    // register busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (wb_live) begin
                busy[wb_addr] <= 1'b0;
            end
            if (wa_live) begin
                busy[wa_addr] <= 1'b0;
            end
            if (set_live) begin
                busy[sb_set_addr] <= 1'b1;
            end
        end
    end

    // One bypass/busy-forwarding slice per read port
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;

        assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

        rf_read_bypass #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .addr        (addr_k),
            .wa_en       (wa_en),
            .wa_addr     (wa_addr),
            .wa_data     (wa_data),
            .wb_en       (wb_en),
            .wb_addr     (wb_addr),
            .wb_data     (wb_data),
            .stored_data (regs[addr_k]),
            .stored_busy (busy[addr_k]),
            .data        (rd_data[k*DATA_W +: DATA_W]),
            .busy        (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp
// Directed, table-driven bench for reg_file_mp with two read ports.
// Each table row is one clock cycle: inputs are driven just after a rising
// edge and the combinational outputs are compared on the falling edge,
// before the row's writes and sets commit.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wa_en;
    logic [AW-1:0]     wa_addr;
    logic [DW-1:0]     wa_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              sb_set_en;
    logic [AW-1:0]     sb_set_addr;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic          rst;
        logic          wa_en;
        logic [AW-1:0] wa_addr;
        logic [DW-1:0] wa_data;
        logic          wb_en;
        logic [AW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
        logic          sb_en;
        logic [AW-1:0] sb_addr;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] exp_d0;
        logic [DW-1:0] exp_d1;
        logic [1:0]    exp_busy;
        string         name;
    } vec_t;

    vec_t vecs [$];

    reg_file_mp #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_RD  (NR),
        .SP_IDX  (29),
        .SP_INIT (32'h0000_0FFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck run still ends with a report
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic rst,
                                input logic wae, input int waa, input logic [DW-1:0] wad,
                                input logic wbe, input int wba, input logic [DW-1:0] wbd,
                                input logic sbe, input int sba,
                                input int r0, input int r1,
                                input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                input logic [1:0] eb, input string nm);
        vec_t v;
        v.rst = rst;
        v.wa_en = wae;  v.wa_addr = AW'(waa); v.wa_data = wad;
        v.wb_en = wbe;  v.wb_addr = AW'(wba); v.wb_data = wbd;
        v.sb_en = sbe;  v.sb_addr = AW'(sba);
        v.ra0 = AW'(r0); v.ra1 = AW'(r1);
        v.exp_d0 = e0; v.exp_d1 = e1; v.exp_busy = eb;
        v.name = nm;
        return v;
    endfunction

    // Drive one cycle's inputs just after the rising edge
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        reset       = v.rst;
        wa_en       = v.wa_en;
        wa_addr     = v.wa_addr;
        wa_data     = v.wa_data;
        wb_en       = v.wb_en;
        wb_addr     = v.wb_addr;
        wb_data     = v.wb_data;
        sb_set_en   = v.sb_en;
        sb_set_addr = v.sb_addr;
        rd_addr     = {v.ra1, v.ra0};
    endtask

    // Compare the combinational outputs on the falling edge
    task automatic checkOutput(input vec_t v);
        @(negedge clk);
        vec_count++;
        if (rd_data[DW-1:0] !== v.exp_d0) begin
            miss_count++;
            $display("[TB] FAIL %s data0: got %h expected %h", v.name, rd_data[DW-1:0], v.exp_d0);
        end
        if (rd_data[2*DW-1:DW] !== v.exp_d1) begin
            miss_count++;
            $display("[TB] FAIL %s data1: got %h expected %h", v.name, rd_data[2*DW-1:DW], v.exp_d1);
        end
        if (rd_busy !== v.exp_busy) begin
            miss_count++;
            $display("[TB] FAIL %s busy: got %b expected %b", v.name, rd_busy, v.exp_busy);
        end
    endtask

    initial begin
        vec_t v;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;

        reset = 1'b1;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0;
        rd_addr = '0;

        // Directed cycle table; state carries from row to row
        vecs.push_back(mk(0, 1, A1_REG, 32'hDEADBEEF, 0, 0, 0, 0, 0, A1_REG, 29,
                          32'hDEADBEEF, 32'h00000FFF, 2'b00, "wa_bypass_r5"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, A1_REG, 0,
                          32'hDEADBEEF, 32'h0, 2'b00, "r5_stored"));
        vecs.push_back(mk(0, 1, A3_REG, 32'h11111111, 1, A3_REG, 32'h22222222, 0, 0, A3_REG, A3_REG,
                          32'h11111111, 32'h11111111, 2'b00, "a_beats_b_bypass"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, A3_REG, A1_REG,
                          32'h11111111, 32'hDEADBEEF, 2'b00, "a_beats_b_stored"));
        vecs.push_back(mk(0, 1, ZERO_REG, 32'hFFFFFFFF, 1, ZERO_REG, 32'hFFFFFFFF, 1, ZERO_REG, 0, 0,
                          32'h0, 32'h0, 2'b00, "r0_write_set"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          32'h0, 32'h0, 2'b00, "r0_after"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, T3_REG, T3_REG, 0,
                          32'h0, 32'h0, 2'b00, "set_r11_not_yet"));
        vecs.push_back(mk(0, 0, 0, 0, 1, T3_REG, 32'hCAFE0011, 1, T3_REG, T3_REG, T3_REG,
                          32'hCAFE0011, 32'hCAFE0011, 2'b00, "r11_write_and_set"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, T3_REG, T3_REG,
                          32'hCAFE0011, 32'hCAFE0011, 2'b11, "r11_set_wins"));
        vecs.push_back(mk(0, 1, T3_REG, 32'h12345678, 0, 0, 0, 0, 0, T3_REG, A1_REG,
                          32'h12345678, 32'hDEADBEEF, 2'b00, "r11_clear_write"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, A3_REG, T3_REG, A3_REG,
                          32'h12345678, 32'h11111111, 2'b00, "r11_cleared_set_r7"));
        vecs.push_back(mk(0, 0, 0, 0, 1, A1_REG, 32'h0000BBBB, 0, 0, A3_REG, A1_REG,
                          32'h11111111, 32'h0000BBBB, 2'b01, "r7_busy_wb_r5"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, A1_REG, A3_REG,
                          32'h0000BBBB, 32'h11111111, 2'b10, "r5_stored_r7_busy"));
        vecs.push_back(mk(1, 1, 3, 32'h00000005, 0, 0, 0, 1, 3, 3, A1_REG,
                          32'h00000005, 32'h0000BBBB, 2'b00, "reset_bypass_r3"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, A3_REG,
                          32'h0, 32'h0, 2'b00, "after_reset_r3_r7"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 29, A1_REG,
                          32'h00000FFF, 32'h0, 2'b00, "after_reset_sp"));

        // Hold reset across two edges
        repeat (2) @(posedge clk);

        // Read every index in pairs straight after reset
        for (int i = 0; i < 32; i += 2) begin
            e0 = (i == 29)     ? 32'h00000FFF : 32'h0;
            e1 = (i + 1 == 29) ? 32'h00000FFF : 32'h0;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, i, i + 1, e0, e1, 2'b00,
                   $sformatf("reset_read_r%0d", i));
            applyStimulus(v);
            checkOutput(v);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
